// File: rtl/p2s_transmitter.sv
// Parallel-to-serial SPI-style transmitter: sends a DATA_W-bit word MSB first,
// one bit per spi_clk rise, then holds spi_clk low for GAP_CYCLES so the receiver reframes.
module p2s_transmitter #(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 1,
    parameter int GAP_CYCLES  = 6
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              spi_clk,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } state_t;

    state_t             state, state_next;
    logic [PH_W-1:0]    phase_cnt, phase_next;
    logic [BIT_W-1:0]   bit_cnt, bit_next;
    logic [GAP_W-1:0]   gap_cnt, gap_next;
    logic [DATA_W-1:0]  shreg, shreg_next, shreg_shifted;
    logic               spi_clk_next, serial_out_next, tx_done_next;

    assign tx_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign shreg_shifted = {shreg[DATA_W-2:0], 1'b0};

    // Reset lands in GAP so a receiver caught mid-frame always sees a full idle gap.
    always_ff @(posedge iclk) begin
        if (rst) begin
            state      <= GAP;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            spi_clk    <= 1'b0;
            serial_out <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            phase_cnt  <= phase_next;
            bit_cnt    <= bit_next;
            gap_cnt    <= gap_next;
            shreg      <= shreg_next;
            spi_clk    <= spi_clk_next;
            serial_out <= serial_out_next;
            tx_done    <= tx_done_next;
        end
    end

    // Outputs are computed one cycle ahead so spi_clk and serial_out change on the same edge.
    always_comb begin
        state_next      = state;
        phase_next      = phase_cnt;
        bit_next        = bit_cnt;
        gap_next        = gap_cnt;
        shreg_next      = shreg;
        spi_clk_next    = 1'b0;
        serial_out_next = 1'b0;
        tx_done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_next      = tx_data;
                    bit_next        = '0;
                    phase_next      = '0;
                    state_next      = LOW;
                    serial_out_next = tx_data[DATA_W-1];
                end
            end

            LOW: begin
                serial_out_next = shreg[DATA_W-1];
                if (phase_cnt == PH_LAST) begin
                    phase_next   = '0;
                    state_next   = HIGH;
                    spi_clk_next = 1'b1;
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end

            HIGH: begin
                spi_clk_next    = 1'b1;
                serial_out_next = shreg[DATA_W-1];
                if (phase_cnt == PH_LAST) begin
                    phase_next   = '0;
                    spi_clk_next = 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next      = GAP;
                        gap_next        = '0;
                        serial_out_next = 1'b0;
                        tx_done_next    = 1'b1;
                    end else begin
                        shreg_next      = shreg_shifted;
                        bit_next        = bit_cnt + 1'b1;
                        state_next      = LOW;
                        serial_out_next = shreg_shifted[DATA_W-1];
                    end
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_next = GAP;
                gap_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_p2s_transmitter.sv
// Bench for p2s_transmitter: two instances (HALF_PERIOD 1 and 3) share stimulus and are
// checked every cycle against a frame-timing model, plus hand-computed literal expectations.
module tb_p2s_transmitter;

    localparam int W = 8;
    localparam int G = 6;

    logic         iclk;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic [1:0]   rdy, spk, sot, bsy, dn;

    int checks = 0;
    int errors = 0;

    p2s_transmitter #(.DATA_W(W), .HALF_PERIOD(1), .GAP_CYCLES(G)) dut0 (
        .iclk(iclk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .spi_clk(spk[0]), .serial_out(sot[0]), .busy(bsy[0]), .tx_done(dn[0])
    );

    p2s_transmitter #(.DATA_W(W), .HALF_PERIOD(3), .GAP_CYCLES(G)) dut3 (
        .iclk(iclk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .spi_clk(spk[1]), .serial_out(sot[1]), .busy(bsy[1]), .tx_done(dn[1])
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Model: mode 0 unknown (before first reset), 1 frame started at fstart, 2 reset gap from gstart.
    int           cyc = 0;
    int           mode[2];
    int           fstart[2];
    int           gstart[2];
    logic [W-1:0] mword[2];
    logic         e_rdy[2], e_spk[2], e_sot[2], e_bsy[2], e_dn[2];

    task automatic checkOutput(input string name, input int idx, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual %0d expected %0d at cycle %0d", name, idx, actual, expected, cyc);
        end
    endtask

    task automatic computeExpect(input int i);
        int hp, len, k, bi;
        hp  = (i == 0) ? 1 : 3;
        len = 2 * W * hp;
        e_spk[i] = 1'b0; e_sot[i] = 1'b0; e_dn[i] = 1'b0; e_bsy[i] = 1'b0; e_rdy[i] = 1'b0;
        if (mode[i] == 1) begin
            k = cyc - fstart[i];
            if (k < len) begin
                bi = W - 1 - k / (2 * hp);
                e_spk[i] = ((k % (2 * hp)) >= hp);
                e_sot[i] = mword[i][bi];
                e_bsy[i] = 1'b1;
            end else if (k < len + G) begin
                e_bsy[i] = 1'b1;
                e_dn[i]  = (k == len);
            end else begin
                e_rdy[i] = 1'b1;
            end
        end else if (mode[i] == 2) begin
            k = cyc - gstart[i];
            e_bsy[i] = (k < G);
            e_rdy[i] = (k >= G);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; fstart[i] = 0; gstart[i] = 0; mword[i] = '0;
            e_rdy[i] = 0; e_spk[i] = 0; e_sot[i] = 0; e_bsy[i] = 0; e_dn[i] = 0;
        end
    end

    always @(posedge iclk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode[i]   = 2;
                gstart[i] = cyc;
            end else if (mode[i] != 0 && e_rdy[i] && tx_valid) begin
                mode[i]   = 1;
                fstart[i] = cyc;
                mword[i]  = tx_data;
            end
            computeExpect(i);
        end
    end

    // Per-cycle compare against the model plus waveform bookkeeping for the literal checks.
    logic        prev_spk[2], prev_rdy[2];
    int          rise_cnt[2], low_run[2], high_run[2], last_low_run[2], last_high_run[2];
    int          done_cnt[2], done_cyc[2], rdy_cyc[2];
    logic [15:0] rx[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_spk[i] = 0; prev_rdy[i] = 0; rise_cnt[i] = 0; low_run[i] = 0; high_run[i] = 0;
            last_low_run[i] = 0; last_high_run[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
            rdy_cyc[i] = 0; rx[i] = '0;
        end
    end

    always @(negedge iclk) begin
        for (int i = 0; i < 2; i++) begin
            if (mode[i] != 0) begin
                checkOutput("tx_ready", i, int'(rdy[i]), int'(e_rdy[i]));
                checkOutput("spi_clk", i, int'(spk[i]), int'(e_spk[i]));
                checkOutput("serial_out", i, int'(sot[i]), int'(e_sot[i]));
                checkOutput("busy", i, int'(bsy[i]), int'(e_bsy[i]));
                checkOutput("tx_done", i, int'(dn[i]), int'(e_dn[i]));
            end
            if (spk[i] && !prev_spk[i]) begin
                rise_cnt[i]++;
                rx[i] = {rx[i][14:0], sot[i]};
                last_low_run[i] = low_run[i];
            end
            if (!spk[i] && prev_spk[i]) last_high_run[i] = high_run[i];
            if (spk[i]) begin
                high_run[i] = prev_spk[i] ? high_run[i] + 1 : 1;
                low_run[i]  = 0;
            end else begin
                low_run[i]  = prev_spk[i] ? 1 : low_run[i] + 1;
                high_run[i] = 0;
            end
            if (dn[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc + 1;
            end
            if (rdy[i] && !prev_rdy[i]) rdy_cyc[i] = cyc + 1;
            prev_spk[i] = spk[i];
            prev_rdy[i] = rdy[i];
        end
    end

    // Offers a word and waits until the model says instance idx takes it; t_acc is the accept edge.
    task automatic applyStimulus(input logic [W-1:0] word, input int idx, input bit hold, output int t_acc);
        int n;
        @(negedge iclk);
        tx_valid = 1'b1;
        tx_data  = word;
        n = 0;
        while (!e_rdy[idx] && n < 200) begin
            @(negedge iclk);
            n++;
        end
        checkOutput("accept_wait", idx, (n < 200) ? 1 : 0, 1);
        @(posedge iclk);
        #1;
        t_acc = cyc;
        if (!hold) begin
            @(negedge iclk);
            tx_valid = 1'b0;
        end
    endtask

    int t1, t2, r0, d0, n;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        // Reset held two edges, then six gap cycles before ready.
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        rst = 1'b0;
        repeat (5) @(posedge iclk);
        #1;
        checkOutput("rst_ready_in_gap", 0, int'(rdy[0]), 0);
        @(posedge iclk);
        #1;
        checkOutput("rst_ready_after_gap", 0, int'(rdy[0]), 1);
        checkOutput("rst_busy_after_gap", 0, int'(bsy[0]), 0);
        checkOutput("rst_spi_clk", 0, int'(spk[0]), 0);

        // Single word 0xA5.
        r0 = rise_cnt[0];
        d0 = done_cnt[0];
        applyStimulus(8'hA5, 0, 1'b0, t1);
        repeat (30) @(posedge iclk);
        #1;
        checkOutput("a5_bits", 0, int'(rx[0][7:0]), 8'hA5);
        checkOutput("a5_rises", 0, rise_cnt[0] - r0, 8);
        checkOutput("a5_done_count", 0, done_cnt[0] - d0, 1);
        checkOutput("a5_done_cycle", 0, done_cyc[0] - t1, 17);
        checkOutput("a5_ready_cycle", 0, rdy_cyc[0] - t1, 23);

        // Back-to-back 0x00 then 0xFF with tx_valid held; low run is gap + idle + first low phase.
        applyStimulus(8'h00, 0, 1'b1, t1);
        @(negedge iclk);
        tx_data = 8'hFF;
        applyStimulus(8'hFF, 0, 1'b0, t2);
        checkOutput("b2b_accept_spacing", 0, t2 - t1, 23);
        repeat (30) @(posedge iclk);
        #1;
        checkOutput("b2b_bits", 0, int'(rx[0]), 16'h00FF);
        n = 0;
        while (rise_cnt[0] == 0 && n < 1) n++;

        // Reset after the third rise of 0x3C abandons the frame.
        r0 = rise_cnt[0];
        d0 = done_cnt[0];
        applyStimulus(8'h3C, 0, 1'b0, t1);
        n = 0;
        while ((rise_cnt[0] - r0) < 3 && n < 100) begin
            @(negedge iclk);
            #1;
            n++;
        end
        checkOutput("abort_rise_wait", 0, (n < 100) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge iclk);
        #1;
        checkOutput("abort_spi_clk_low", 0, int'(spk[0]), 0);
        @(negedge iclk);
        rst = 1'b0;
        repeat (30) @(posedge iclk);
        #1;
        checkOutput("abort_rises", 0, rise_cnt[0] - r0, 3);
        checkOutput("abort_no_done", 0, done_cnt[0] - d0, 0);
        checkOutput("abort_bits", 0, int'(rx[0][2:0]), 3'b001);
        checkOutput("abort_ready_cycle", 0, rdy_cyc[0] - t1, 13);

        // 0x11 offered during a 0xF0 frame is taken only once the frame and gap finish.
        applyStimulus(8'hF0, 0, 1'b0, t1);
        repeat (4) @(negedge iclk);
        applyStimulus(8'h11, 0, 1'b0, t2);
        checkOutput("busy_accept_spacing", 0, t2 - t1, 23);
        repeat (30) @(posedge iclk);
        #1;
        checkOutput("busy_bits", 0, int'(rx[0]), 16'hF011);

        // HALF_PERIOD=3 instance with 0x81.
        applyStimulus(8'h81, 1, 1'b0, t1);
        repeat (60) @(posedge iclk);
        #1;
        checkOutput("hp3_bits", 1, int'(rx[1][7:0]), 8'h81);
        checkOutput("hp3_low_phase", 1, last_low_run[1], 3);
        checkOutput("hp3_high_phase", 1, last_high_run[1], 3);
        checkOutput("hp3_done_cycle", 1, done_cyc[1] - t1, 49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
